// File: rtl/fwd_hazard_unit.sv
// Execute-stage forwarding and load-use hazard detection for a 5-stage pipeline.
// Keeps shadow EX/MEM/WB slots of register-usage metadata in lockstep with the datapath.
module fwd_hazard_unit #(
  parameter int NB_REG = 5,
  parameter int NB_SEL = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stall,
  input  logic              i_flush_id,
  input  logic              i_id_valid,
  input  logic [NB_REG-1:0] i_id_rs,
  input  logic [NB_REG-1:0] i_id_rt,
  input  logic [NB_REG-1:0] i_id_dest,
  input  logic              i_id_reg_write,
  input  logic              i_id_mem_read,
  input  logic              i_id_use_rs,
  input  logic              i_id_use_rt_alu,
  input  logic              i_id_use_rt_store,
  output logic [NB_SEL-1:0] o_fwd_a,
  output logic [NB_SEL-1:0] o_fwd_b,
  output logic [NB_SEL-1:0] o_forwarding_mux,
  output logic              o_load_use_stall
);

  localparam logic [NB_SEL-1:0] ALU_REG = NB_SEL'(0);
  localparam logic [NB_SEL-1:0] ALU_MEM = NB_SEL'(1);
  localparam logic [NB_SEL-1:0] ALU_WB  = NB_SEL'(2);
  localparam logic [NB_SEL-1:0] ST_MEM  = NB_SEL'(0);
  localparam logic [NB_SEL-1:0] ST_WB   = NB_SEL'(1);
  localparam logic [NB_SEL-1:0] ST_REG  = NB_SEL'(2);

  typedef struct packed {
    logic              valid;
    logic [NB_REG-1:0] rs;
    logic [NB_REG-1:0] rt;
    logic [NB_REG-1:0] dest;
    logic              reg_write;
    logic              mem_read;
    logic              use_rs;
    logic              use_rt_alu;
    logic              use_rt_store;
  } ex_slot_t;

  typedef struct packed {
    logic              valid;
    logic [NB_REG-1:0] dest;
    logic              reg_write;
    logic              mem_read;
  } mem_slot_t;

  typedef struct packed {
    logic              valid;
    logic [NB_REG-1:0] dest;
    logic              reg_write;
  } wb_slot_t;

  ex_slot_t  ex_q;
  mem_slot_t mem_q;
  wb_slot_t  wb_q;
  ex_slot_t  id_slot;

  logic mem_can_fwd;
  logic wb_can_fwd;
  logic mem_hit_rs;
  logic mem_hit_rt;
  logic wb_hit_rs;
  logic wb_hit_rt;
  logic ex_is_load;
  logic id_needs_load;

  // A load in MEM only has its address on the MEM bus, so it is excluded here.
  assign mem_can_fwd = mem_q.valid & mem_q.reg_write & ~mem_q.mem_read & (mem_q.dest != '0);
  assign wb_can_fwd  = wb_q.valid & wb_q.reg_write & (wb_q.dest != '0);

  assign mem_hit_rs = mem_can_fwd & (mem_q.dest == ex_q.rs);
  assign mem_hit_rt = mem_can_fwd & (mem_q.dest == ex_q.rt);
  assign wb_hit_rs  = wb_can_fwd & (wb_q.dest == ex_q.rs);
  assign wb_hit_rt  = wb_can_fwd & (wb_q.dest == ex_q.rt);

  always_comb begin
    o_fwd_a          = ALU_REG;
    o_fwd_b          = ALU_REG;
    o_forwarding_mux = ST_REG;
    if (ex_q.valid) begin
      if (ex_q.use_rs) begin
        if (mem_hit_rs)     o_fwd_a = ALU_MEM;
        else if (wb_hit_rs) o_fwd_a = ALU_WB;
      end
      if (ex_q.use_rt_alu) begin
        if (mem_hit_rt)     o_fwd_b = ALU_MEM;
        else if (wb_hit_rt) o_fwd_b = ALU_WB;
      end
      if (ex_q.use_rt_store) begin
        if (mem_hit_rt)     o_forwarding_mux = ST_MEM;
        else if (wb_hit_rt) o_forwarding_mux = ST_WB;
      end
    end
  end

  assign ex_is_load    = ex_q.valid & ex_q.mem_read & ex_q.reg_write & (ex_q.dest != '0);
  assign id_needs_load = (i_id_use_rs & (i_id_rs == ex_q.dest))
                       | ((i_id_use_rt_alu | i_id_use_rt_store) & (i_id_rt == ex_q.dest));
  assign o_load_use_stall = i_id_valid & ex_is_load & id_needs_load;

  assign id_slot = '{
    valid:        i_id_valid,
    rs:           i_id_rs,
    rt:           i_id_rt,
    dest:         i_id_dest,
    reg_write:    i_id_reg_write,
    mem_read:     i_id_mem_read,
    use_rs:       i_id_use_rs,
    use_rt_alu:   i_id_use_rt_alu,
    use_rt_store: i_id_use_rt_store
  };

  // Freeze holds everything; flush and load-use stall both collapse to one bubble.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!i_stall) begin
      wb_q.valid      <= mem_q.valid;
      wb_q.dest       <= mem_q.dest;
      wb_q.reg_write  <= mem_q.reg_write;
      mem_q.valid     <= ex_q.valid;
      mem_q.dest      <= ex_q.dest;
      mem_q.reg_write <= ex_q.reg_write;
      mem_q.mem_read  <= ex_q.mem_read;
      if (i_flush_id || o_load_use_stall) ex_q <= '0;
      else                                ex_q <= id_slot;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an instruction-level model.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       i_reset;
  logic       i_stall;
  logic       i_flush_id;
  logic       i_id_valid;
  logic [4:0] i_id_rs;
  logic [4:0] i_id_rt;
  logic [4:0] i_id_dest;
  logic       i_id_reg_write;
  logic       i_id_mem_read;
  logic       i_id_use_rs;
  logic       i_id_use_rt_alu;
  logic       i_id_use_rt_store;
  logic [1:0] o_fwd_a;
  logic [1:0] o_fwd_b;
  logic [1:0] o_forwarding_mux;
  logic       o_load_use_stall;

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit #(.NB_REG(5), .NB_SEL(2)) dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .i_stall          (i_stall),
    .i_flush_id       (i_flush_id),
    .i_id_valid       (i_id_valid),
    .i_id_rs          (i_id_rs),
    .i_id_rt          (i_id_rt),
    .i_id_dest        (i_id_dest),
    .i_id_reg_write   (i_id_reg_write),
    .i_id_mem_read    (i_id_mem_read),
    .i_id_use_rs      (i_id_use_rs),
    .i_id_use_rt_alu  (i_id_use_rt_alu),
    .i_id_use_rt_store(i_id_use_rt_store),
    .o_fwd_a          (o_fwd_a),
    .o_fwd_b          (o_fwd_b),
    .o_forwarding_mux (o_forwarding_mux),
    .o_load_use_stall (o_load_use_stall)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- instruction-level model ----------------
  typedef struct packed {
    bit       valid;
    bit [4:0] rs, rt, dest;
    bit       rw, mr, urs, urta, urts;
  } instr_t;

  instr_t m_ex, m_mem, m_wb;
  bit     model_ok = 1'b0;

  // Which older stage supplies src: 0 register file, 1 MEM, 2 WB (nearest wins).
  function automatic int supplier(input bit [4:0] src);
    instr_t older[2];
    older[0] = m_mem;
    older[1] = m_wb;
    if (src == 5'd0) return 0;
    for (int s = 0; s < 2; s++)
      if (older[s].valid && older[s].rw && older[s].dest == src && !(s == 0 && older[s].mr))
        return s + 1;
    return 0;
  endfunction

  function automatic bit model_stall();
    bit dep;
    if (!(i_id_valid && m_ex.valid && m_ex.mr && m_ex.rw && m_ex.dest != 5'd0)) return 1'b0;
    dep = (i_id_use_rs && i_id_rs == m_ex.dest) ||
          ((i_id_use_rt_alu || i_id_use_rt_store) && i_id_rt == m_ex.dest);
    return dep;
  endfunction

  function automatic logic [6:0] model_out();
    logic [1:0] a, b, m;
    int sa, sb;
    a = 2'd0; b = 2'd0; m = 2'd2;
    sa = supplier(m_ex.rs);
    sb = supplier(m_ex.rt);
    if (m_ex.valid) begin
      if (m_ex.urs)  a = (sa == 1) ? 2'd1 : (sa == 2) ? 2'd2 : 2'd0;
      if (m_ex.urta) b = (sb == 1) ? 2'd1 : (sb == 2) ? 2'd2 : 2'd0;
      if (m_ex.urts) m = (sb == 1) ? 2'd0 : (sb == 2) ? 2'd1 : 2'd2;
    end
    return {a, b, m, model_stall()};
  endfunction

  always @(posedge clk) begin
    if (i_reset) begin
      m_ex     <= '0;
      m_mem    <= '0;
      m_wb     <= '0;
      model_ok <= 1'b1;
    end else if (!i_stall) begin
      m_wb  <= m_mem;
      m_mem <= m_ex;
      if (i_flush_id || model_stall()) m_ex <= '0;
      else m_ex <= '{valid: i_id_valid, rs: i_id_rs, rt: i_id_rt, dest: i_id_dest,
                     rw: i_id_reg_write, mr: i_id_mem_read, urs: i_id_use_rs,
                     urta: i_id_use_rt_alu, urts: i_id_use_rt_store};
    end
  end

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      logic [6:0] exp;
      exp_q.push_back(model_out());
      exp = exp_q.pop_front();
      check("cycle {fwd_a,fwd_b,mux,stall}",
            {o_fwd_a, o_fwd_b, o_forwarding_mux, o_load_use_stall}, exp);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] d,
                        input bit rw, input bit mr, input bit urs, input bit urta, input bit urts);
    i_id_valid = v; i_id_rs = rs; i_id_rt = rt; i_id_dest = d;
    i_id_reg_write = rw; i_id_mem_read = mr;
    i_id_use_rs = urs; i_id_use_rt_alu = urta; i_id_use_rt_store = urts;
  endtask

  task automatic nop_id();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_id();
    bit [4:0] rs, rt, d;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    d  = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 5))
      0: set_id(0, rs, rt, d, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      1: set_id(1, rs, rt, d, 1, 0, 1, 1, 0);   // R-type
      2: set_id(1, rs, rt, rt, 1, 0, 1, 0, 0);  // immediate ALU
      3: set_id(1, rs, rt, rt, 1, 1, 1, 0, 0);  // load
      4: set_id(1, rs, rt, d, 0, 0, 1, 0, 1);   // store
      default: set_id(1, rs, rt, d, 1, 0, 0, 1, 0); // shift by shamt
    endcase
  endtask

  task automatic lit(input string name, input logic [1:0] act, input logic [1:0] exp);
    check(name, {5'd0, act}, {5'd0, exp});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_reset = 1; i_stall = 0; i_flush_id = 0;
    nop_id();
    step(); step();
    i_reset = 0;
    lit("reset fwd_a", o_fwd_a, 2'b00);
    lit("reset fwd_b", o_fwd_b, 2'b00);
    lit("reset mux", o_forwarding_mux, 2'b10);
    lit("reset stall", {1'b0, o_load_use_stall}, 2'b00);

    // ADD r3 -> SUB rs=3 rt=4 back to back
    set_id(1, 1, 2, 3, 1, 0, 1, 1, 0); step();
    set_id(1, 3, 4, 5, 1, 0, 1, 1, 0); step();
    lit("add-sub fwd_a", o_fwd_a, 2'b01);
    lit("add-sub fwd_b", o_fwd_b, 2'b00);
    // one NOP between
    set_id(1, 1, 2, 3, 1, 0, 1, 1, 0); step();
    nop_id(); step();
    set_id(1, 3, 4, 5, 1, 0, 1, 1, 0); step();
    lit("add-nop-sub fwd_a", o_fwd_a, 2'b10);

    // two writers of r5, MEM priority; r0 never forwarded
    set_id(1, 1, 2, 5, 1, 0, 1, 1, 0); step();
    set_id(1, 2, 1, 5, 1, 0, 1, 1, 0); step();
    set_id(1, 5, 1, 6, 1, 0, 1, 1, 0); step();
    lit("mem priority fwd_a", o_fwd_a, 2'b01);
    set_id(1, 1, 2, 0, 1, 0, 1, 1, 0); step();
    set_id(1, 0, 1, 6, 1, 0, 1, 1, 0); step();
    lit("r0 fwd_a", o_fwd_a, 2'b00);

    // LW r7 -> ADD rs=7: one stall cycle then WB forward
    set_id(1, 1, 7, 7, 1, 1, 1, 0, 0); step();
    set_id(1, 7, 1, 8, 1, 0, 1, 1, 0); #1;
    lit("lw-add stall", {1'b0, o_load_use_stall}, 2'b01);
    step();
    lit("lw-add stall gone", {1'b0, o_load_use_stall}, 2'b00);
    lit("lw-add bubble fwd_a", o_fwd_a, 2'b00);
    step(); nop_id(); #1;
    lit("lw-add wb fwd_a", o_fwd_a, 2'b10);
    lit("lw-add no stall", {1'b0, o_load_use_stall}, 2'b00);

    // LW r7 -> SW rt=7
    set_id(1, 1, 7, 7, 1, 1, 1, 0, 0); step();
    set_id(1, 1, 7, 0, 0, 0, 1, 0, 1); #1;
    lit("lw-sw stall", {1'b0, o_load_use_stall}, 2'b01);
    step(); step(); nop_id(); #1;
    lit("lw-sw mux", o_forwarding_mux, 2'b01);

    // immediate, store, shift gating
    set_id(1, 1, 3, 2, 1, 0, 1, 1, 0); step();
    set_id(1, 1, 2, 2, 1, 0, 1, 0, 0); step();
    lit("addi fwd_b", o_fwd_b, 2'b00);
    set_id(1, 1, 3, 2, 1, 0, 1, 1, 0); step();
    set_id(1, 1, 2, 0, 0, 0, 1, 0, 1); step();
    lit("add-sw mux", o_forwarding_mux, 2'b00);
    set_id(1, 1, 3, 4, 1, 0, 1, 1, 0); step();
    set_id(1, 4, 1, 6, 1, 0, 0, 1, 0); step();
    lit("sll fwd_a", o_fwd_a, 2'b00);

    // freeze with dependence in flight
    set_id(1, 1, 2, 3, 1, 0, 1, 1, 0); step();
    set_id(1, 3, 4, 5, 1, 0, 1, 1, 0); step();
    nop_id(); i_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      lit("frozen fwd_a", o_fwd_a, 2'b01);
    end
    i_stall = 0;

    // flush of dependent ID instruction
    set_id(1, 1, 2, 3, 1, 0, 1, 1, 0); step();
    set_id(1, 3, 4, 5, 1, 0, 1, 1, 0); i_flush_id = 1; step();
    i_flush_id = 0; nop_id(); #1;
    lit("flush fwd_a", o_fwd_a, 2'b00);

    // reset during freeze
    set_id(1, 1, 2, 3, 1, 0, 1, 1, 0); step();
    set_id(1, 3, 3, 5, 1, 0, 1, 1, 1); step();
    i_stall = 1; i_reset = 1; step();
    i_stall = 0; i_reset = 0; nop_id(); #1;
    lit("reset in stall fwd_a", o_fwd_a, 2'b00);
    lit("reset in stall mux", o_forwarding_mux, 2'b10);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rand_id();
      i_stall    = ($urandom_range(0, 9) == 0);
      i_flush_id = ($urandom_range(0, 9) == 0);
      i_reset    = ($urandom_range(0, 99) == 0);
      step();
    end
    i_reset = 0; i_stall = 0; i_flush_id = 0; nop_id();
    step();
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Producer side of the execute-stage forwarding interface: generates the operand-A, operand-B and store-data forwarding selects, plus the load-use stall.
- Keeps its own shadow pipeline of register-usage metadata (EX, MEM and WB slots) that advances in lockstep with the datapath pipeline registers.
- Sits beside ID/EX: reads decode-stage register fields and drives forwarding controls to the execute stage and the stall to IF/ID.

Parameters:
NB_REG, 5, register-index width
NB_SEL, 2, forwarding-select width

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_reset  in  1  synchronous, active-high reset
i_stall  in  1  global pipeline freeze (debug/halt); all slots hold
i_flush_id  in  1  taken branch/jump; instruction in ID becomes a bubble
i_id_valid  in  1  ID holds a real instruction
i_id_rs  in  NB_REG  rs field of ID instruction
i_id_rt  in  NB_REG  rt field of ID instruction
i_id_dest  in  NB_REG  already-resolved destination register (rd/rt/31)
i_id_reg_write  in  1  ID instruction writes the register file
i_id_mem_read  in  1  ID instruction is a load
i_id_use_rs  in  1  rs is an ALU operand (0 for shamt shifts, jumps)
i_id_use_rt_alu  in  1  rt is the ALU B operand (0 when the immediate is selected)
i_id_use_rt_store  in  1  rt is store data
o_fwd_a  out  NB_SEL  operand-A select: 00 regfile/shamt, 01 MEM, 10 WB
o_fwd_b  out  NB_SEL  operand-B select: 00 regfile/immediate, 01 MEM, 10 WB
o_forwarding_mux  out  NB_SEL  store-data select: 00 MEM, 01 WB, 10 regfile
o_load_use_stall  out  1  freeze PC and IF/ID; bubble into EX

Behaviour:
- State: EX slot {valid, rs, rt, dest, reg_write, mem_read, use_rs, use_rt_alu, use_rt_store}; MEM slot {valid, dest, reg_write, mem_read}; WB slot {valid, dest, reg_write}.
- Reset: all slot fields are 0. Outputs after reset: o_fwd_a=00, o_fwd_b=00, o_forwarding_mux=10, o_load_use_stall=0.
- Advance on each clock edge, with i_reset taking highest priority:
  - i_stall=1: all slots hold. i_stall overrides i_flush_id and o_load_use_stall.
  - Otherwise: WB<=MEM, MEM<=EX.
  - EX<=bubble (all zero) if i_flush_id or o_load_use_stall; else EX<=ID fields, with valid=i_id_valid.
- "Producer match" definitions:
  - MEM match: MEM.valid & MEM.reg_write & ~MEM.mem_read & MEM.dest!=0 & MEM.dest==src.
  - WB match: WB.valid & WB.reg_write & WB.dest!=0 & WB.dest==src.
  - A MEM-slot load never forwards from MEM, because the MEM forward bus carries the address. In that case the WB check applies.
- Forward outputs are combinational from registered slots, so there is zero added latency.
  - o_fwd_a: 01 if EX.use_rs & MEM match(EX.rs); else 10 if EX.use_rs & WB match(EX.rs); else 00.
  - o_fwd_b: same rule with EX.rt, gated by EX.use_rt_alu. It is never nonzero when the immediate is the operand.
  - o_forwarding_mux: 00 on MEM match(EX.rt), 01 on WB match(EX.rt), else 10; gated by EX.use_rt_store.
  - MEM has priority over WB when both match (younger result wins).
  - Register 0 is never forwarded. EX.valid=0 forces the defaults 00/00/10.
- o_load_use_stall (combinational) = i_id_valid & EX.valid & EX.mem_read & EX.reg_write & EX.dest!=0, AND at least one of:
  - i_id_use_rs & i_id_rs==EX.dest
  - (i_id_use_rt_alu | i_id_use_rt_store) & i_id_rt==EX.dest
- Stall lasts exactly one cycle per load: the next edge moves the load to MEM and puts a bubble in EX. The consumer then receives a WB forward one cycle later.
- i_flush_id together with o_load_use_stall: a single bubble is inserted. No double counting.
- Reset asserted mid-operation clears all slots on that edge, regardless of i_stall.

Test Plan:
- Reset, then idle -> o_fwd_a=00, o_fwd_b=00, o_forwarding_mux=10, o_load_use_stall=0.
- ADD r3 (dest 3, reg_write) then SUB rs=3, rt=4 (use_rs, use_rt_alu) back-to-back -> when SUB is in EX, o_fwd_a=01, o_fwd_b=00. Insert one NOP between them -> o_fwd_a=10.
- Two writers to r5 in consecutive cycles, consumer rs=5 next -> o_fwd_a=01 (MEM priority). Writer dest=0 -> o_fwd_a=00.
- LW dest=7 then ADD rs=7 -> o_load_use_stall=1 for exactly one cycle, EX bubble inserted; next cycle with ADD in EX, o_fwd_a=10 and stall=0. SW rt=7 after LW -> also stalls, then o_forwarding_mux=01.
- ADDI rt=2 immediate (use_rt_alu=0) after writer r2 -> o_fwd_b=00. SW rt=2 after ADD dest 2 -> o_forwarding_mux=00. SLL (use_rs=0) after writer of its rs -> o_fwd_a=00.
- i_stall=1 for 3 cycles with ADD→SUB dependence in flight -> outputs frozen. i_flush_id with dependent ID instruction -> bubble in EX, o_fwd_a=00 next cycle. i_reset asserted during i_stall -> all slots cleared on that edge.
